mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
//
// PURPOSE
//   Initiator side of the data-memory port. Accepts one load/store request at a
//   time from the MEM stage, drives wite_mem/read_mem/raw_flag/raw_addr/data_in
//   of the data Memory, and returns sign- or zero-extended load data. Stalls the
//   pipeline while an access is in flight. Rejects misaligned accesses without
//   touching memory.
//
// PARAMETERS
//   DATA_W      32  data width; matches Rreg_Bus
//   ADDR_W      32  byte-address width of req_addr
//   ACC_CYCLES  1   cycles the memory strobe is held (1..15)
//
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   req_valid  in   1       request present
//   req_ready  out  1       unit can accept; request is taken when valid&&ready
//   req_we     in   1       1 = store, 0 = load
//   req_size   in   2       00 word, 01 half, 10 byte, 11 word
//   req_sext   in   1       loads: 1 = sign-extend, 0 = zero-extend
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   DATA_W  store data (low bits used for half/byte)
//   resp_valid out  1       one-cycle pulse: access finished
//   resp_rdata out  DATA_W  extended load data; 0 for stores and errors
//   resp_err   out  1       valid with resp_valid: misaligned, no access made
//   busy       out  1       stall to pipeline; high in any state but IDLE
//   wite_mem   out  1       memory write strobe
//   read_mem   out  1       memory read strobe
//   raw_flag   out  2       size code to memory (= latched req_size)
//   raw_addr   out  DATA_W  memory address (mapping below)
//   data_in    out  DATA_W  store data to memory
//   data_out   in   DATA_W  word read back from memory
//
// BEHAVIOUR
//   Reset (async, rst=1): state IDLE. req_ready=1, all other outputs 0.
//   FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE; IDLE -> DONE on misalign.
//   - IDLE: req_ready=1. On valid&&ready, latch we/size/sext/addr/wdata.
//     Misalign check: word needs addr[1:0]==0; half needs addr[0]==0; byte
//     never misaligns. Misaligned -> DONE with err flag set; no strobe issued.
//   - SETUP (1 cycle): raw_addr/raw_flag/data_in driven from latches, strobes 0.
//   - ACCESS (ACC_CYCLES cycles, down-counter): wite_mem=we, read_mem=!we.
//     Address/data stable all cycles. data_out captured on last ACCESS cycle.
//   - DONE (1 cycle): strobes 0, address held; resp_valid=1; then IDLE.
//   busy=1 and req_ready=0 in SETUP/ACCESS/DONE; req_valid there is ignored.
//   Latency: valid&&ready at edge N -> resp_valid high in cycle N+2+ACC_CYCLES;
//   misaligned: resp_valid in cycle N+1. Back-to-back issue: next request
//   accepted the cycle after DONE.
//   raw_addr mapping (A = latched byte address):
//     reads, word stores: A>>2; half stores: A>>1 (raw_addr[0]=A[1]);
//     byte stores: A (memory decodes A[1:0]).
//   Load lane extract from captured word W:
//     word: W; half: A[1]=0 -> W[31:16], A[1]=1 -> W[15:0];
//     byte: A[1:0]=00..11 -> W[7:0],W[15:8],W[23:16],W[31:24].
//     Extend to DATA_W: sext ? replicate lane MSB : zero-fill.
//   Outputs registered; no combinational path req_* -> memory outputs.
//   rst mid-access: strobes drop immediately, no resp_valid, back to IDLE.
//
// TESTING
//   1 Store word 0xDEADBEEF @0x10 then load word @0x10 -> raw_addr=0x4 both,
//     wite_mem high ACC_CYCLES cycles, resp_rdata=0xDEADBEEF, resp_err=0.
//   2 Byte load @0x13, W=0x80FF7F01, sext=1 -> 0xFFFFFF80; sext=0 -> 0x80.
//   3 Half load @0x12, W=0x1234F00D, sext=1 -> 0xFFFFF00D; @0x10 -> 0x1234.
//   4 Word load @0x0A -> resp_err=1 next cycle, wite_mem/read_mem never high,
//     resp_rdata=0.
//   5 ACC_CYCLES=3, req_valid held high -> req_ready low 5 cycles/request,
//     resp_valid exactly one pulse per accepted request, second request
//     accepted the cycle after first DONE.
//   6 Assert rst during ACCESS of a store -> wite_mem falls asynchronously,
//     no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Initiator side of the data-memory port. It takes one load/store request
//   at a time from the MEM stage and drives the data-memory strobes, address,
//   size code and store data. Load data is returned sign- or zero-extended.
//   Misaligned requests are answered with an error and never reach memory.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake; taken when both are high
//   req_we                1 = store, 0 = load
//   req_size              00 word, 01 half, 10 byte, 11 word
//   req_sext              loads: 1 = sign-extend, 0 = zero-extend
//   req_addr              byte address
//   req_wdata             store data (low bits used for half/byte)
//   resp_valid            one-cycle pulse when the access finishes
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_err              misaligned request, no memory access made
//   busy                  pipeline stall, high whenever not idle
//   wite_mem/read_mem     memory write/read strobes
//   raw_flag              size code to memory
//   raw_addr              memory address
//   data_in               store data to memory
//   data_out              word read back from memory
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int ACC_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sext,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic              wite_mem,
   output logic              read_mem,
   output logic [1:0]        raw_flag,
   output logic [DATA_W-1:0] raw_addr,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                sext_q, sext_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                accept;
   logic                misalign;
   logic [7:0]          byte_lane [4];
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [DATA_W-1:0]   load_ext;
   logic [ADDR_W-1:0]   map_addr;

   assign accept = req_valid && (state_q == S_IDLE);

   always_comb begin
      misalign = 1'b0;
      case (req_size)
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = 1'b0;
         default: misalign = (req_addr[1:0] != 2'b00);
      endcase
   end

   // Byte lanes of the returned word; the lane order is the memory's own
   // (half at A[1]=0 comes from the upper 16 bits).
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = data_out[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      byte_sel = byte_lane[addr_q[1:0]];
      half_sel = addr_q[1] ? data_out[15:0] : data_out[31:16];
      case (size_q)
         2'b01:   load_ext = {{(DATA_W-16){sext_q & half_sel[15]}}, half_sel};
         2'b10:   load_ext = {{(DATA_W-8){sext_q & byte_sel[7]}}, byte_sel};
         default: load_ext = data_out;
      endcase
   end

   // Reads and word stores address words; narrower stores address finer
   // units so the memory can pick the lane itself.
   always_comb begin
      if (!we_q || size_q == 2'b00 || size_q == 2'b11)
         map_addr = addr_q >> 2;
      else if (size_q == 2'b01)
         map_addr = addr_q >> 1;
      else
         map_addr = addr_q;
   end

   // State register and datapath latches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and latch update
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = req_size;
               sext_d  = req_sext;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = misalign;
               rdata_d = '0;
               state_d = misalign ? S_DONE : S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = CNT_INIT;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!we_q)
                  rdata_d = load_ext;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      wite_mem   = 1'b0;
      read_mem   = 1'b0;
      raw_flag   = 2'b00;
      raw_addr   = '0;
      data_in    = '0;
      if (state_q != S_IDLE) begin
         raw_flag = size_q;
         raw_addr = DATA_W'(map_addr);
         data_in  = we_q ? wdata_q : '0;
      end
      if (state_q == S_ACCESS) begin
         wite_mem = we_q;
         read_mem = !we_q;
      end
      if (state_q == S_DONE) begin
         resp_valid = 1'b1;
         resp_err   = err_q;
         resp_rdata = rdata_q;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int ACC = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_sext;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, busy, wite_mem, read_mem;
   logic [31:0] resp_rdata, raw_addr, data_in, data_out;
   logic [1:0]  raw_flag;

   int compared = 0;
   int mismatched = 0;

   // transaction observations
   logic [31:0] t_rdata, t_addr, t_din;
   logic [1:0]  t_flag;
   logic        t_err;
   int          t_lat, t_wr, t_rd;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32), .ACC_CYCLES(ACC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .busy(busy), .wite_mem(wite_mem), .read_mem(read_mem),
      .raw_flag(raw_flag), .raw_addr(raw_addr), .data_in(data_in),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   // Issue one request and observe it until resp_valid (bounded).
   task automatic do_req(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_we = we; req_size = size; req_sext = sext; req_addr = addr;
      req_wdata = wdata; req_valid = 1'b1;
      t_rdata = '0; t_addr = '0; t_din = '0; t_flag = '0; t_err = 1'b0;
      t_lat = -1; t_wr = 0; t_rd = 0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (wite_mem) begin t_wr++; t_addr = raw_addr; t_din = data_in; t_flag = raw_flag; end
         if (read_mem) begin t_rd++; t_addr = raw_addr; t_flag = raw_flag; end
         if (resp_valid) begin
            t_rdata = resp_rdata; t_err = resp_err; t_lat = n;
            break;
         end
      end
      $display("txn we=%0b size=%0d sext=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h raw_addr=%h wr=%0d rd=%0d",
               we, size, sext, addr, wdata, t_lat, t_err, t_rdata, t_addr, t_wr, t_rd);
      // resp_valid must be a single-cycle pulse
      @(negedge clk);
      compared++;
      if (resp_valid !== 1'b0) begin
         mismatched++; $display("FAIL pulse_width: resp_valid=%b required 0", resp_valid);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_sext = 1'b0; req_addr = '0; req_wdata = '0; data_out = '0;
      repeat (2) @(negedge clk);
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
      compared++; if ({wite_mem, read_mem, resp_valid, resp_err} !== 4'b0) begin mismatched++; $display("FAIL rst_strobes: got %b want 0000", {wite_mem, read_mem, resp_valid, resp_err}); end
      compared++; if (raw_addr !== 32'h0 || resp_rdata !== 32'h0 || data_in !== 32'h0) begin mismatched++; $display("FAIL rst_buses: raw_addr=%h rdata=%h data_in=%h want 0", raw_addr, resp_rdata, data_in); end
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_store_load_word;
      logic [31:0] stored;
      do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
      compared++; if (t_lat !== 2 + ACC) begin mismatched++; $display("FAIL sw_latency: got %0d want %0d", t_lat, 2 + ACC); end
      compared++; if (t_wr !== ACC || t_rd !== 0) begin mismatched++; $display("FAIL sw_strobes: wr=%0d rd=%0d want %0d/0", t_wr, t_rd, ACC); end
      compared++; if (t_addr !== 32'h4) begin mismatched++; $display("FAIL sw_addr: got %h want 00000004", t_addr); end
      compared++; if (t_din !== 32'hDEADBEEF) begin mismatched++; $display("FAIL sw_data: got %h want deadbeef", t_din); end
      compared++; if (t_err !== 1'b0 || t_rdata !== 32'h0) begin mismatched++; $display("FAIL sw_resp: err=%b rdata=%h want 0/0", t_err, t_rdata); end
      stored = t_din;
      data_out = stored;
      do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      compared++; if (t_rd !== ACC || t_wr !== 0) begin mismatched++; $display("FAIL lw_strobes: rd=%0d wr=%0d want %0d/0", t_rd, t_wr, ACC); end
      compared++; if (t_addr !== 32'h4) begin mismatched++; $display("FAIL lw_addr: got %h want 00000004", t_addr); end
      compared++; if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0) begin mismatched++; $display("FAIL lw_data: got %h err=%b want deadbeef/0", t_rdata, t_err); end
   endtask

   task automatic test_byte_load;
      data_out = 32'h80FF7F01;
      do_req(1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
      compared++; if (t_rdata !== 32'hFFFFFF80) begin mismatched++; $display("FAIL lb_sext: got %h want ffffff80", t_rdata); end
      compared++; if (t_addr !== 32'h4 || t_flag !== 2'b10) begin mismatched++; $display("FAIL lb_addr: addr=%h flag=%b want 00000004/10", t_addr, t_flag); end
      do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
      compared++; if (t_rdata !== 32'h00000080) begin mismatched++; $display("FAIL lb_zext: got %h want 00000080", t_rdata); end
      do_req(1'b0, 2'b10, 1'b1, 32'h11, 32'h0);
      compared++; if (t_rdata !== 32'h0000007F) begin mismatched++; $display("FAIL lb_lane1: got %h want 0000007f", t_rdata); end
      do_req(1'b0, 2'b10, 1'b1, 32'h12, 32'h0);
      compared++; if (t_rdata !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL lb_lane2: got %h want ffffffff", t_rdata); end
   endtask

   task automatic test_half_load;
      data_out = 32'h1234F00D;
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      compared++; if (t_rdata !== 32'hFFFFF00D) begin mismatched++; $display("FAIL lh_hi_addr: got %h want fffff00d", t_rdata); end
      do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      compared++; if (t_rdata !== 32'h00001234) begin mismatched++; $display("FAIL lh_lo_addr: got %h want 00001234", t_rdata); end
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      compared++; if (t_rdata !== 32'h0000F00D) begin mismatched++; $display("FAIL lh_zext: got %h want 0000f00d", t_rdata); end
   endtask

   task automatic test_store_mapping;
      do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hCAFE5A5A);
      compared++; if (t_addr !== 32'hB || t_flag !== 2'b01) begin mismatched++; $display("FAIL sh_addr: addr=%h flag=%b want 0000000b/01", t_addr, t_flag); end
      compared++; if (t_din !== 32'hCAFE5A5A) begin mismatched++; $display("FAIL sh_data: got %h want cafe5a5a", t_din); end
      do_req(1'b1, 2'b10, 1'b0, 32'h13, 32'h000000A5);
      compared++; if (t_addr !== 32'h13 || t_flag !== 2'b10) begin mismatched++; $display("FAIL sb_addr: addr=%h flag=%b want 00000013/10", t_addr, t_flag); end
      do_req(1'b1, 2'b11, 1'b0, 32'h24, 32'h11223344);
      compared++; if (t_addr !== 32'h9 || t_wr !== ACC) begin mismatched++; $display("FAIL sw11_addr: addr=%h wr=%0d want 00000009/%0d", t_addr, t_wr, ACC); end
   endtask

   task automatic test_misalign;
      data_out = 32'hFFFFFFFF;
      do_req(1'b0, 2'b00, 1'b1, 32'h0A, 32'h0);
      compared++; if (t_err !== 1'b1 || t_lat !== 1) begin mismatched++; $display("FAIL mis_word: err=%b lat=%0d want 1/1", t_err, t_lat); end
      compared++; if (t_wr !== 0 || t_rd !== 0) begin mismatched++; $display("FAIL mis_strobes: wr=%0d rd=%0d want 0/0", t_wr, t_rd); end
      compared++; if (t_rdata !== 32'h0) begin mismatched++; $display("FAIL mis_rdata: got %h want 0", t_rdata); end
      do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234);
      compared++; if (t_err !== 1'b1 || t_wr !== 0 || t_lat !== 1) begin mismatched++; $display("FAIL mis_half: err=%b wr=%0d lat=%0d want 1/0/1", t_err, t_wr, t_lat); end
   endtask

   task automatic test_back_to_back;
      int low_cnt;
      logic [11:0] resp_seen, ready_seen;
      data_out = 32'h0BADF00D;
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0; req_addr = 32'h40;
      req_valid = 1'b1;
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready0: got %b want 1", req_ready); end
      low_cnt = 0; resp_seen = '0; ready_seen = '0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         resp_seen[c] = resp_valid;
         ready_seen[c] = req_ready;
         if (!req_ready) low_cnt++;
      end
      req_valid = 1'b0;
      $display("b2b ready=%b resp=%b low=%0d", ready_seen, resp_seen, low_cnt);
      compared++; if (low_cnt !== 10) begin mismatched++; $display("FAIL b2b_low: got %0d want 10", low_cnt); end
      compared++; if (resp_seen !== 12'b1000_0010_0000) begin mismatched++; $display("FAIL b2b_resp: got %b want 100000100000", resp_seen); end
      compared++; if (ready_seen !== 12'b0000_0100_0000) begin mismatched++; $display("FAIL b2b_accept: got %b want 000001000000", ready_seen); end
      repeat (2) @(negedge clk);
      compared++; if (req_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: ready=%b busy=%b want 1/0", req_ready, busy); end
   endtask

   task automatic test_reset_mid;
      logic saw_resp;
      logic saw_wr;
      saw_resp = 1'b0; saw_wr = 1'b0;
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 0; n < 10 && !saw_wr; n++) begin
         @(negedge clk);
         saw_wr = wite_mem;
      end
      compared++; if (saw_wr !== 1'b1) begin mismatched++; $display("FAIL rmid_access: wite_mem=%b want 1", saw_wr); end
      #2 rst = 1'b1;
      #1;
      compared++; if (wite_mem !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rmid_async: wite_mem=%b busy=%b want 0/0", wite_mem, busy); end
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (resp_valid) saw_resp = 1'b1;
      end
      compared++; if (saw_resp !== 1'b0) begin mismatched++; $display("FAIL rmid_resp: resp_valid seen=%b want 0", saw_resp); end
      compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
      $display("reset during store access done");
   endtask

   initial begin
      test_reset();
      test_store_load_word();
      test_byte_load();
      test_half_load();
      test_store_mapping();
      test_misalign();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
